// File: rtl/exec_pkg.sv
// Shared types and constants for the LC-3 execute stage.
package exec_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        AND = 2'b01,
        NOT = 2'b10,
        MUL = 2'b11
    } aluk_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned MUL_ITERS     = 16;
    localparam int unsigned ITER_W        = $clog2(MUL_ITERS);

endpackage

// File: rtl/exec_unit_mul.sv
// Iterative shift-add multiplier: one partial product per step, low WIDTH bits kept.
module mul_shift_add
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             init,
    input  logic             step,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] acc_next,
    output logic             last
);

    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH-1:0]  acc;
    logic [ITER_W-1:0] count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            count <= '0;
        end else if (init) begin
            a     <= a_in;
            b     <= b_in;
            acc   <= '0;
            count <= '0;
        end else if (step) begin
            acc   <= acc_next;
            a     <= a << 1;
            b     <= b >> 1;
            count <= count + 1'b1;
        end
    end

    // acc_next is exposed so the final iteration's sum lands in Result on the same edge
    assign acc_next = b[0] ? acc + a : acc;
    assign last     = (count == ITER_W'(MUL_ITERS - 1));

endmodule

// File: rtl/exec_unit.sv
// LC-3 execute stage: single-cycle ADD/AND/NOT, 16-cycle MUL, result register and NZP codes.
module exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       ALUK,
    input  logic             SR2MUX,
    input  logic [4:0]       IMM5,
    input  logic [WIDTH-1:0] SR1OUT,
    input  logic [WIDTH-1:0] SR2OUT,
    input  logic             LD_CC,
    input  logic [WIDTH-1:0] BUS,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             Busy,
    output logic             N,
    output logic             Z,
    output logic             P
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] mul_acc_next;
    logic             mul_init;
    logic             mul_step;
    logic             mul_last;
    logic             res_load;

    assign opb = SR2MUX ? {{(WIDTH-5){IMM5[4]}}, IMM5} : SR2OUT;

    always_comb begin
        alu_res = '0;
        case (aluk_t'(ALUK))
            ADD:     alu_res = SR1OUT + opb;
            AND:     alu_res = SR1OUT & opb;
            NOT:     alu_res = ~SR1OUT;
            default: alu_res = '0;
        endcase
    end

    mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .Clk      (Clk),
        .Reset    (Reset),
        .init     (mul_init),
        .step     (mul_step),
        .a_in     (SR1OUT),
        .b_in     (opb),
        .acc_next (mul_acc_next),
        .last     (mul_last)
    );

    always_comb begin
        state_next = state;
        mul_init   = 1'b0;
        mul_step   = 1'b0;
        res_load   = 1'b0;
        res_next   = alu_res;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (aluk_t'(ALUK) == MUL) begin
                        mul_init   = 1'b1;
                        state_next = CALC;
                    end else begin
                        res_load   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            CALC: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    res_load   = 1'b1;
                    res_next   = mul_acc_next;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            Result <= '0;
        end else begin
            state <= state_next;
            if (res_load)
                Result <= res_next;
        end
    end

    assign Busy = (state == CALC);
    assign Done = (state == DONE);

    // Condition codes run independently of the FSM so LD_CC never disturbs a MUL
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            N <= 1'b0;
            Z <= 1'b1;
            P <= 1'b0;
        end else if (LD_CC) begin
            N <= BUS[WIDTH-1];
            Z <= (BUS == '0);
            P <= !BUS[WIDTH-1] && (BUS != '0);
        end
    end

endmodule
